// File: rtl/riscv_mult_wb_buffer_pkg.sv
// Shared types and constants for the multiplier writeback buffer.
// An entry pairs a finished multiplier result with its destination register.
package riscv_mult_wb_buffer_pkg;

  localparam int MULT_WB_DEPTH      = 2;
  localparam int MULT_WB_DATA_WIDTH = 32;
  localparam int MULT_WB_ADDR_WIDTH = 6;

  typedef struct packed {
    logic [MULT_WB_DATA_WIDTH-1:0] result;
    logic [MULT_WB_ADDR_WIDTH-1:0] waddr;
  } mult_wb_entry_t;

endpackage

// File: rtl/riscv_mult_wb_fwd_match.sv
// Forwarding lookup for one operand read port.
// Scans the buffered entries and returns the youngest valid entry whose
// destination matches the read address. Address 0 never hits.
module riscv_mult_wb_fwd_match
  import riscv_mult_wb_buffer_pkg::*;
#(
  parameter int DEPTH      = MULT_WB_DEPTH,
  parameter int DATA_WIDTH = MULT_WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = MULT_WB_ADDR_WIDTH
) (
  input  mult_wb_entry_t [DEPTH-1:0]         entries,
  input  logic [DEPTH-1:0]                   valid,
  input  logic [$clog2(DEPTH)-1:0]           wr_ptr,
  input  logic [ADDR_WIDTH-1:0]              raddr,
  output logic                               hit,
  output logic [DATA_WIDTH-1:0]              data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1) so that the
  // last match written, i.e. the youngest one, is the one that sticks.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int age = DEPTH; age >= 1; age--) begin
      idx = wr_ptr - PTR_W'(age);
      if (valid[idx] && (entries[idx].waddr == raddr) && (raddr != '0)) begin
        hit  = 1'b1;
        data = entries[idx].result;
      end
    end
  end

endmodule

// File: rtl/riscv_mult_wb_buffer.sv
// Result buffer sitting right after the subword multiplier/MAC unit.
// Decouples the multiplier from writeback arbitration: finished results are
// queued with their destination and drained in order through the writeback
// port, while both operand read ports can pick up still-buffered results.
// Outputs depend on registered state only, so a result pushed this cycle is
// first visible one cycle later.
module riscv_mult_wb_buffer
  import riscv_mult_wb_buffer_pkg::*;
#(
  parameter int DEPTH      = MULT_WB_DEPTH,
  parameter int DATA_WIDTH = MULT_WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = MULT_WB_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_WIDTH-1:0]     in_result_i,
  input  logic [ADDR_WIDTH-1:0]     in_waddr_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_WIDTH-1:0]     out_result_o,
  output logic [ADDR_WIDTH-1:0]     out_waddr_o,
  input  logic [2*ADDR_WIDTH-1:0]   fwd_raddr_i,
  output logic [1:0]                fwd_hit_o,
  output logic [2*DATA_WIDTH-1:0]   fwd_data_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mult_wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]           entry_valid;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic                       pop;

  // Handshake flags come from the occupancy register only, so in_ready_o
  // never depends on out_ready_i and the multiplier sees a stable ready.
  assign in_ready_o   = (count != CNT_W'(DEPTH));
  assign out_valid_o  = (count != '0);
  assign push         = in_valid_i & in_ready_o;
  assign pop          = out_valid_o & out_ready_i;
  assign out_result_o = out_valid_o ? entries[rd_ptr].result : '0;
  assign out_waddr_o  = out_valid_o ? entries[rd_ptr].waddr  : '0;
  assign count_o      = count;

  // Pointer, occupancy and entry storage. Reset also scrubs the stored data;
  // flush only drops the entries. Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries     <= '0;
      entry_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (flush_i) begin
      entry_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr].result <= in_result_i;
        entries[wr_ptr].waddr  <= in_waddr_i;
        entry_valid[wr_ptr]    <= 1'b1;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // One lookup per operand read port; port a sits in the low slice.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    riscv_mult_wb_fwd_match #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_match (
      .entries (entries),
      .valid   (entry_valid),
      .wr_ptr  (wr_ptr),
      .raddr   (fwd_raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .hit     (fwd_hit_o[p]),
      .data    (fwd_data_o[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_riscv_mult_wb_buffer.sv
// Self-checking bench for riscv_mult_wb_buffer.
// A scoreboard queue receives every accepted result and is drained against
// every writeback handshake; directed checks cover reset, backpressure,
// forwarding priority, wrap-around, flush and reset.
module tb_riscv_mult_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_result_i;
  logic [5:0]  in_waddr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [5:0]  out_waddr_o;
  logic [5:0]  raddr_a;
  logic [5:0]  raddr_b;
  logic [1:0]  fwd_hit_o;
  logic [63:0] fwd_data_o;
  logic [1:0]  count_o;

  int          checks = 0;
  int          errors = 0;
  logic [37:0] sb[$];
  logic [37:0] exp_entry;

  riscv_mult_wb_buffer #(
    .DEPTH      (2),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_result_i  (in_result_i),
    .in_waddr_i   (in_waddr_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_waddr_o  (out_waddr_o),
    .fwd_raddr_i  ({raddr_b, raddr_a}),
    .fwd_hit_o    (fwd_hit_o),
    .fwd_data_o   (fwd_data_o),
    .count_o      (count_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] result, input logic [5:0] waddr);
    in_valid_i  = valid;
    in_result_i = result;
    in_waddr_i  = waddr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: on the falling edge, record what the next rising edge will
  // push and compare what it will pop. Flush or reset empties the model.
  always @(negedge clk) begin
    if (rst || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        checkOutput("sb_pop_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_entry = sb.pop_front();
          checkOutput("sb_data", {26'd0, out_result_o, out_waddr_o}, {26'd0, exp_entry});
        end
      end
      if (in_valid_i && in_ready_o) begin
        sb.push_back({in_result_i, in_waddr_i});
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences followed by the randomised multiplier stream.
  initial begin
    int produced;
    int gap;
    int cyc;
    logic fire;

    rst = 1'b1;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    raddr_a = 6'd5;
    raddr_b = 6'd0;
    applyStimulus(1'b0, 32'd0, 6'd0);
    tick();
    tick();

    checkOutput("rst_in_ready", in_ready_o, 1);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_out_result", out_result_o, 0);
    checkOutput("rst_out_waddr", out_waddr_o, 0);
    checkOutput("rst_fwd_hit", fwd_hit_o, 0);
    checkOutput("rst_fwd_data", fwd_data_o, 0);
    checkOutput("rst_count", count_o, 0);
    rst = 1'b0;
    tick();

    $display("[TB] single result passthrough");
    out_ready_i = 1'b1;
    applyStimulus(1'b1, 32'h0000_0006, 6'd5);
    #1;
    checkOutput("t1_no_comb_path", out_valid_o, 0);
    tick();
    applyStimulus(1'b0, 32'd0, 6'd0);
    checkOutput("t1_out_valid", out_valid_o, 1);
    checkOutput("t1_out_result", out_result_o, 32'h6);
    checkOutput("t1_out_waddr", out_waddr_o, 5);
    checkOutput("t1_count", count_o, 1);
    checkOutput("t1_fwd_hit_a", fwd_hit_o[0], 1);
    checkOutput("t1_fwd_data_a", fwd_data_o[31:0], 32'h6);
    tick();
    checkOutput("t1_count_drained", count_o, 0);
    checkOutput("t1_out_valid_drained", out_valid_o, 0);

    $display("[TB] fill under stall");
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'hAAAA_0001, 6'd3);
    tick();
    applyStimulus(1'b1, 32'hBBBB_0002, 6'd4);
    tick();
    applyStimulus(1'b1, 32'hCCCC_0003, 6'd9);
    checkOutput("t2_count_full", count_o, 2);
    checkOutput("t2_in_ready_full", in_ready_o, 0);
    tick();
    tick();
    tick();
    checkOutput("t2_count_held", count_o, 2);
    checkOutput("t2_head_first", out_result_o, 32'hAAAA_0001);
    applyStimulus(1'b0, 32'd0, 6'd0);
    out_ready_i = 1'b1;
    tick();
    checkOutput("t2_head_second", out_result_o, 32'hBBBB_0002);
    checkOutput("t2_waddr_second", out_waddr_o, 4);
    tick();
    checkOutput("t2_count_empty", count_o, 0);

    $display("[TB] forwarding priority");
    out_ready_i = 1'b0;
    raddr_a = 6'd7;
    raddr_b = 6'd0;
    applyStimulus(1'b1, 32'd11, 6'd7);
    tick();
    applyStimulus(1'b1, 32'd22, 6'd7);
    #1;
    checkOutput("t3_push_not_fwd_hit", fwd_hit_o[0], 1);
    checkOutput("t3_push_not_fwd_data", fwd_data_o[31:0], 32'd11);
    tick();
    applyStimulus(1'b0, 32'd0, 6'd0);
    checkOutput("t3_count", count_o, 2);
    checkOutput("t3_youngest_hit", fwd_hit_o[0], 1);
    checkOutput("t3_youngest_data", fwd_data_o[31:0], 32'd22);
    out_ready_i = 1'b1;
    tick();
    checkOutput("t3_count_one", count_o, 1);
    checkOutput("t3_popping_hit", fwd_hit_o[0], 1);
    checkOutput("t3_popping_data", fwd_data_o[31:0], 32'd22);
    tick();
    checkOutput("t3_hit_after_drain", fwd_hit_o[0], 0);
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'd33, 6'd0);
    tick();
    applyStimulus(1'b0, 32'd0, 6'd0);
    checkOutput("t3_zero_count", count_o, 1);
    checkOutput("t3_zero_hit_b", fwd_hit_o[1], 0);
    checkOutput("t3_zero_data_b", fwd_data_o[63:32], 0);
    checkOutput("t3_stale_hit_a", fwd_hit_o[0], 0);
    out_ready_i = 1'b1;
    tick();

    $display("[TB] streaming push and pop");
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'd100, 6'd1);
    tick();
    out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(200 + i), 6'((i % 7) + 1));
      tick();
      checkOutput("t4_count_steady", count_o, 1);
    end
    applyStimulus(1'b0, 32'd0, 6'd0);
    tick();
    checkOutput("t4_count_drained", count_o, 0);

    $display("[TB] flush and reset");
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h51, 6'd10);
    tick();
    applyStimulus(1'b1, 32'h52, 6'd11);
    tick();
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'h53, 6'd12);
    raddr_a = 6'd10;
    raddr_b = 6'd11;
    tick();
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'd0, 6'd0);
    checkOutput("t5_flush_count", count_o, 0);
    checkOutput("t5_flush_out_valid", out_valid_o, 0);
    checkOutput("t5_flush_fwd_hit", fwd_hit_o, 0);
    checkOutput("t5_flush_in_ready", in_ready_o, 1);
    raddr_a = 6'd12;
    tick();
    checkOutput("t5_flush_push_lost", count_o, 0);
    checkOutput("t5_flush_push_fwd", fwd_hit_o, 0);

    applyStimulus(1'b1, 32'h61, 6'd13);
    tick();
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'h62, 6'd14);
    raddr_a = 6'd14;
    raddr_b = 6'd13;
    tick();
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'd0, 6'd0);
    checkOutput("t5_flush1_count", count_o, 0);
    checkOutput("t5_flush1_fwd_hit", fwd_hit_o, 0);
    tick();
    checkOutput("t5_flush1_push_lost", count_o, 0);

    applyStimulus(1'b1, 32'h71, 6'd15);
    tick();
    applyStimulus(1'b1, 32'h72, 6'd16);
    tick();
    applyStimulus(1'b0, 32'd0, 6'd0);
    raddr_a = 6'd15;
    raddr_b = 6'd16;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_rst_count", count_o, 0);
    checkOutput("t5_rst_out_valid", out_valid_o, 0);
    checkOutput("t5_rst_out_result", out_result_o, 0);
    checkOutput("t5_rst_out_waddr", out_waddr_o, 0);
    checkOutput("t5_rst_in_ready", in_ready_o, 1);
    checkOutput("t5_rst_fwd_hit", fwd_hit_o, 0);

    $display("[TB] multiplier stream with random writeback stalls");
    produced = 0;
    gap = 4;
    cyc = 0;
    while (produced < 40 && cyc < 3000) begin
      out_ready_i = ($urandom_range(0, 9) < 2);
      if (!in_valid_i) begin
        if (gap == 0) begin
          applyStimulus(1'b1, $urandom, 6'($urandom_range(1, 63)));
        end else begin
          gap--;
        end
      end
      #1;
      fire = in_valid_i && in_ready_o;
      tick();
      cyc++;
      if (fire) begin
        applyStimulus(1'b0, 32'd0, 6'd0);
        produced++;
        gap = 4;
      end
    end
    checkOutput("t6_all_produced", produced, 40);
    out_ready_i = 1'b1;
    for (int k = 0; k < 50 && count_o != 0; k++) begin
      tick();
    end
    checkOutput("t6_drained_count", count_o, 0);
    checkOutput("t6_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
